clk_div_prog: RTL and testbench

//  Runtime-programmable integer clock divider, successor to the fixed-N divider.
//  - Divisor is loaded through a valid/ready config port.
//  - New divisors and enable changes take effect only at period boundaries,
//    so clk_out never shows a truncated or runt pulse.
//  - Odd divisors produce exactly 50% duty using a negedge helper.
//  - Drives LED/peripheral timing from the 12 MHz board clock; also emits a
//    clk-domain period tick for synchronous logic.

---
 rtl/clk_div_prog_if.sv | 12 +
 rtl/clk_div_prog.sv | 96 +++++++++
 tb/tb_clk_div_prog.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_prog_if.sv
// Configuration channel of the programmable clock divider: a divisor
// offered with valid/ready, accepted when both are high on a clock edge.
interface clk_div_prog_if #(
    parameter int WIDTH = 8
);
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;

    modport master (output cfg_valid, output cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with a one-deep pending divisor
// slot; divisor and enable changes only land on period boundaries.
module clk_div_prog #(
    parameter int WIDTH     = 8,
    parameter int DIV_RESET = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    clk_div_prog_if.slave    cfg,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] div_active,
    output logic             running
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] pend_div;
    logic [WIDTH-1:0] div_next;
    logic [WIDTH-1:0] div_eff;
    logic             pend_valid;
    logic             bnd;
    logic             run_next;
    logic             run_eff;
    logic             clk_p;
    logic             clk_p_next;
    logic             clk_n;
    logic             accept;

    assign cfg.cfg_ready = !pend_valid;
    assign accept        = cfg.cfg_valid && !pend_valid;

    // div_eff/run_eff describe the cycle after this edge, so clk_p is already
    // correct for a freshly switched divisor in the first cycle of its period.
    always_comb begin
        bnd        = running ? (cnt == div_active - WIDTH'(1)) : 1'b1;
        div_next   = pend_valid ? pend_div : div_active;
        run_next   = en && (div_next != '0);
        cnt_next   = bnd ? '0 : cnt + WIDTH'(1);
        div_eff    = bnd ? div_next : div_active;
        run_eff    = bnd ? run_next : running;
        clk_p_next = run_eff && (div_eff != WIDTH'(1)) &&
                     (cnt_next < (div_eff >> 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            div_active <= WIDTH'(DIV_RESET);
            pend_div   <= '0;
            pend_valid <= 1'b0;
            running    <= 1'b0;
            clk_p      <= 1'b0;
            tick       <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            clk_p <= clk_p_next;
            tick  <= bnd && run_next;
            if (bnd) begin
                div_active <= div_next;
                running    <= run_next;
            end
            // A slot freed at a boundary can only be refilled on a later edge.
            if (bnd && pend_valid) begin
                pend_valid <= 1'b0;
            end else if (accept) begin
                pend_valid <= 1'b1;
                pend_div   <= cfg.cfg_div;
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_n <= 1'b0;
        end else begin
            clk_n <= clk_p;
        end
    end

    // Odd divisors stretch the high phase by half a cycle through clk_n.
    always_comb begin
        clk_out = 1'b0;
        if (running) begin
            if (div_active == WIDTH'(1)) begin
                clk_out = clk;
            end else if (div_active[0]) begin
                clk_out = clk_p | clk_n;
            end else begin
                clk_out = clk_p;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: waveform shape, boundary-aligned switching,
// handshake back-pressure and asynchronous reset.
module tb_clk_div_prog;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clk_out;
    logic       tick;
    logic [7:0] div_active;
    logic       running;

    int compared   = 0;
    int mismatched = 0;
    int hi_halves;
    int tick_count;

    clk_div_prog_if #(.WIDTH(8)) cfg_bus ();

    clk_div_prog #(.WIDTH(8), .DIV_RESET(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg        (cfg_bus.slave),
        .clk_out    (clk_out),
        .tick       (tick),
        .div_active (div_active),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: got %0d required %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One-cycle config offer; caller ensures cfg_ready is high.
    task automatic applyStimulus(input logic [7:0] d);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_div   = d;
        step();
        cfg_bus.cfg_valid = 1'b0;
    endtask

    task automatic waitTick(input string tag, input int budget);
        int n = 0;
        while (tick !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        checkOutput(tag, 32'(tick), 32'd1);
    endtask

    // Starts at the tick cycle of a period, counts high half-cycles and ticks
    // over n cycles, and ends at the first cycle of the following period.
    task automatic measurePeriod(input int n, output int hi, output int tk);
        hi = 0;
        tk = 0;
        for (int i = 0; i < n; i++) begin
            if (clk_out === 1'b1) hi++;
            if (tick === 1'b1) tk++;
            #5;
            if (clk_out === 1'b1) hi++;
            step();
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        en                = 1'b1;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_div   = 8'd0;

        // T1: reset state, then default divide-by-5
        #23;
        checkOutput("rst_clk_out", 32'(clk_out), 32'd0);
        checkOutput("rst_tick", 32'(tick), 32'd0);
        checkOutput("rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        checkOutput("rst_div", 32'(div_active), 32'd5);
        checkOutput("rst_running", 32'(running), 32'd0);
        rst_n = 1'b1;
        waitTick("t1_first_tick", 10);
        checkOutput("t1_rise_at_start", 32'(clk_out), 32'd1);
        measurePeriod(5, hi_halves, tick_count);
        checkOutput("t1_high_halves", 32'(hi_halves), 32'd5);
        checkOutput("t1_ticks", 32'(tick_count), 32'd1);
        checkOutput("t1_period_len", 32'(tick), 32'd1);

        // T2: switch to 4, then request 6 mid-period
        applyStimulus(8'd4);
        waitTick("t2_tick_div4", 20);
        checkOutput("t2_div4", 32'(div_active), 32'd4);
        measurePeriod(4, hi_halves, tick_count);
        checkOutput("t2_div4_halves", 32'(hi_halves), 32'd4);
        checkOutput("t2_div4_ticks", 32'(tick_count), 32'd1);
        step();
        applyStimulus(8'd6);
        checkOutput("t2_ready_drop", 32'(cfg_bus.cfg_ready), 32'd0);
        checkOutput("t2_div_unchanged", 32'(div_active), 32'd4);
        checkOutput("t2_cnt2_low", 32'(clk_out), 32'd0);
        step();
        checkOutput("t2_div_unchanged_cnt3", 32'(div_active), 32'd4);
        step();
        checkOutput("t2_switch_tick", 32'(tick), 32'd1);
        checkOutput("t2_div6", 32'(div_active), 32'd6);
        checkOutput("t2_ready_back", 32'(cfg_bus.cfg_ready), 32'd1);
        checkOutput("t2_div6_rise", 32'(clk_out), 32'd1);
        measurePeriod(6, hi_halves, tick_count);
        checkOutput("t2_div6_halves", 32'(hi_halves), 32'd6);
        checkOutput("t2_div6_ticks", 32'(tick_count), 32'd1);

        // T3: drop enable at cnt=2, period finishes, then restart
        step();
        step();
        en = 1'b0;
        step();
        checkOutput("t3_still_running", 32'(running), 32'd1);
        checkOutput("t3_cnt3_low", 32'(clk_out), 32'd0);
        step();
        step();
        step();
        checkOutput("t3_stopped", 32'(running), 32'd0);
        checkOutput("t3_stopped_out", 32'(clk_out), 32'd0);
        checkOutput("t3_stopped_tick", 32'(tick), 32'd0);
        step();
        #5;
        checkOutput("t3_stays_low", 32'(clk_out), 32'd0);
        en = 1'b1;
        step();
        checkOutput("t3_restart_running", 32'(running), 32'd1);
        checkOutput("t3_restart_tick", 32'(tick), 32'd1);
        checkOutput("t3_restart_rise", 32'(clk_out), 32'd1);

        // T4: divide-by-1 passthrough, then divide-by-3
        applyStimulus(8'd1);
        waitTick("t4_tick_div1", 20);
        checkOutput("t4_div1", 32'(div_active), 32'd1);
        measurePeriod(3, hi_halves, tick_count);
        checkOutput("t4_div1_halves", 32'(hi_halves), 32'd3);
        checkOutput("t4_div1_ticks", 32'(tick_count), 32'd3);
        applyStimulus(8'd3);
        checkOutput("t4_div1_held", 32'(div_active), 32'd1);
        step();
        checkOutput("t4_div3", 32'(div_active), 32'd3);
        checkOutput("t4_div3_tick", 32'(tick), 32'd1);
        measurePeriod(3, hi_halves, tick_count);
        checkOutput("t4_div3_halves", 32'(hi_halves), 32'd3);
        checkOutput("t4_div3_ticks", 32'(tick_count), 32'd1);

        // T5: stop via divisor 0, then maximum divisor 255
        applyStimulus(8'd0);
        step();
        step();
        checkOutput("t5_stop_running", 32'(running), 32'd0);
        checkOutput("t5_stop_div", 32'(div_active), 32'd0);
        checkOutput("t5_stop_out", 32'(clk_out), 32'd0);
        applyStimulus(8'd255);
        step();
        checkOutput("t5_div255", 32'(div_active), 32'd255);
        checkOutput("t5_div255_tick", 32'(tick), 32'd1);
        measurePeriod(255, hi_halves, tick_count);
        checkOutput("t5_div255_halves", 32'(hi_halves), 32'd255);
        checkOutput("t5_div255_ticks", 32'(tick_count), 32'd1);
        checkOutput("t5_div255_period", 32'(tick), 32'd1);

        // T6: back-to-back configs with valid held through back-pressure
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_div   = 8'd4;
        step();
        cfg_bus.cfg_div   = 8'd7;
        checkOutput("t6_ready_low", 32'(cfg_bus.cfg_ready), 32'd0);
        for (int n = 0; n < 300 && cfg_bus.cfg_ready !== 1'b1; n++) begin
            step();
        end
        checkOutput("t6_ready_rise", 32'(cfg_bus.cfg_ready), 32'd1);
        checkOutput("t6_first_applied", 32'(div_active), 32'd4);
        checkOutput("t6_switch_tick", 32'(tick), 32'd1);
        step();
        cfg_bus.cfg_valid = 1'b0;
        checkOutput("t6_second_taken", 32'(cfg_bus.cfg_ready), 32'd0);
        checkOutput("t6_div_still4", 32'(div_active), 32'd4);
        waitTick("t6_tick_div7", 20);
        checkOutput("t6_div7", 32'(div_active), 32'd7);

        // Reset mid-period with a pending divisor
        applyStimulus(8'd9);
        step();
        checkOutput("t6_pre_reset_high", 32'(clk_out), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_out", 32'(clk_out), 32'd0);
        checkOutput("t6_rst_running", 32'(running), 32'd0);
        checkOutput("t6_rst_tick", 32'(tick), 32'd0);
        checkOutput("t6_rst_div", 32'(div_active), 32'd5);
        checkOutput("t6_rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        #5;
        rst_n = 1'b1;
        waitTick("t6_post_rst_tick", 10);
        checkOutput("t6_pending_lost", 32'(div_active), 32'd5);
        measurePeriod(5, hi_halves, tick_count);
        checkOutput("t6_post_rst_halves", 32'(hi_halves), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
